uart_tx_datapath: RTL and testbench
===================================

Name: uart_tx_datapath

Overview:
Transmit datapath for the UART transmitter, directly downstream of the transmit controller. It consumes the controller's load and baud_enable strobes, and contains the baud-rate tick generator, the 11-bit frame shift register and the bit counter. It drives the serial tx line and returns bit_counter to the controller. Frame format: start(0), 8 data bits LSB first, parity, stop(1).

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 9600, line rate in bits/s; DIVISOR = CLK_FREQ/BAUD (integer division), must be >= 2
PARITY_ODD, 0, 0 = even parity bit, 1 = odd parity bit

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-low reset
load  input  1  from controller: capture data_in and start a new frame
baud_enable  input  1  from controller: run the baud generator and shift
data_in  input  8  byte to transmit, sampled only on a load cycle
tx  output  1  serial line, idle high
bit_counter  output  4  frame bits completed, 0..11, returned to the controller
baud_tick  output  1  single-cycle pulse at each bit boundary, for debug and the bench

Behaviour:
- Reset (reset==0 at posedge):
  - shift_reg = 11'h7FF, so tx = 1.
  - bit_counter = 0; baud counter = 0; baud_tick = 0.
  - Reset overrides load and baud_enable. Reset mid-frame returns tx high on the next cycle.
- tx = shift_reg[0], driven from the register with no combinational path from inputs.
- Load (load==1 at posedge):
  - shift_reg <= {1'b1, parity, data_in[7:0], 1'b0}.
  - bit_counter <= 0; baud counter <= 0.
  - The start bit appears on tx the cycle after the load edge.
  - Load has priority over baud_enable in the same cycle.
  - Load mid-frame aborts the current frame and restarts with the new byte.
- Parity: PARITY_ODD==0 gives ^data_in; PARITY_ODD==1 gives ~^data_in.
- Baud counter width is clog2(DIVISOR).
  - With baud_enable==1 and load==0, it counts 0..DIVISOR-1 and wraps.
  - baud_tick is registered high for exactly the one cycle in which the counter equals DIVISOR-1.
  - With baud_enable==0, the counter is forced to 0, baud_tick = 0, and shift_reg and bit_counter hold. A paused bit restarts its full DIVISOR period on resume.
- On each tick:
  - shift_reg <= {1'b1, shift_reg[10:1]}, shifting in ones.
  - bit_counter <= bit_counter + 1, saturating at 11. Once it reaches 11, further ticks change nothing and tx stays 1.
- Timing: each frame bit is held on tx for exactly DIVISOR cycles. bit_counter becomes 11 at the edge ending the stop bit, 11*DIVISOR cycles after the load edge. Its value between loads holds at 11, which the controller ignores outside TRANS.
- data_in changes outside a load cycle have no effect.

Decomposition:
- Shared package uart_pkg:
  - FRAME_BITS=11, DATA_BITS=8, START_LVL=1'b0, STOP_LVL=1'b1, IDLE_LVL=1'b1.
  - The controller's state encodings IDLE/LOAD/TRANS/HOLD move here too.
- One sub-module, uart_baud_gen: parameter DIVISOR; ports clk, reset, enable, tick. It is reused later by the receiver at 16x oversampling.
- Shift register, parity and bit counter stay in the top module.

Test Plan (CLK_FREQ=40, BAUD=10, so DIVISOR=4, unless noted):
1. reset=0 for 2 cycles, with load=1 and baud_enable=1 driven -> tx=1, bit_counter=0, baud_tick=0 throughout.
2. load pulse with data_in=8'hA5, then baud_enable=1 held, even parity -> tx sequence 0,1,0,1,0,0,1,0,1,0,1, each bit 4 cycles. bit_counter reads 1..11 at cycles 4,8,...,44 after the load edge.
3. data_in=8'h01 with PARITY_ODD=0 -> parity bit 1. Same byte with PARITY_ODD=1 -> parity bit 0. Data bits 1,0,0,0,0,0,0,0 in both cases.
4. Drop baud_enable for 10 cycles, 2 cycles into bit 3 -> tx and bit_counter frozen at 3, no baud_tick. On resume, bit 3 lasts a further full 4 cycles and the frame completes correctly.
5. After bit_counter=11, keep baud_enable=1 for 20 cycles -> bit_counter stays 11, tx stays 1, baud_tick keeps pulsing every 4 cycles.
6. load with data_in=8'h3C during bit 5 of an 8'hFF frame, with baud_enable=1 the same cycle -> bit_counter=0, start bit 0 on the next cycle, 8'h3C frame sent intact. A separate run with reset=0 mid-frame -> tx=1 on the next cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver: frame geometry,
// line levels, controller state encodings and the parity helper.
package uart_pkg;

  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = 8;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    TRANS = 2'd2,
    HOLD  = 2'd3
  } ctrl_state_t;

  // Returns the parity bit that makes the data byte plus parity even (or odd).
  function automatic logic frame_parity(input logic [DATA_BITS-1:0] data,
                                        input logic                 odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period tick generator: while enabled, pulses tick for one cycle every
// DIVISOR cycles; dropping enable clears the count so the period restarts.
module uart_baud_gen #(
  parameter int DIVISOR = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] LAST     = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(DIVISOR - 2);

  logic [CW-1:0] count;

  // tick is registered so that it is high exactly while count sits at LAST.
  always_ff @(posedge clk) begin
    if (!reset || !enable) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + CW'(1);
      end
      tick <= (count == PRE_LAST);
    end
  end

endmodule

// File: rtl/uart_tx_datapath.sv
// UART transmit datapath: frame shift register, parity and bit counter,
// paced by the baud generator and driven by the controller's strobes.
module uart_tx_datapath
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       baud_enable,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic [3:0] bit_counter,
  output logic       baud_tick
);

  localparam int DIVISOR = CLK_FREQ / BAUD;
  localparam logic [3:0] LAST_COUNT = 4'(FRAME_BITS);

  logic [FRAME_BITS-1:0] shift_reg;
  logic                  gen_enable;

  // A load restarts the bit period, so it holds the generator cleared.
  assign gen_enable = baud_enable & ~load;

  uart_baud_gen #(
    .DIVISOR(DIVISOR)
  ) u_baud_gen (
    .clk   (clk),
    .reset (reset),
    .enable(gen_enable),
    .tick  (baud_tick)
  );

  // Shifting stops once all frame bits are out; the register is all ones by then.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_reg   <= {FRAME_BITS{IDLE_LVL}};
      bit_counter <= 4'd0;
    end else if (load) begin
      shift_reg   <= {STOP_LVL, frame_parity(data_in, PARITY_ODD != 0),
                      data_in, START_LVL};
      bit_counter <= 4'd0;
    end else if (baud_enable && baud_tick && (bit_counter != LAST_COUNT)) begin
      shift_reg   <= {IDLE_LVL, shift_reg[FRAME_BITS-1:1]};
      bit_counter <= bit_counter + 4'd1;
    end
  end

  assign tx = shift_reg[0];

endmodule

// File: tb/tb_uart_tx_datapath.sv
// Scoreboard bench: even- and odd-parity datapaths driven in parallel and
// compared every cycle against a bit-time reference model.
module tb_uart_tx_datapath;

  localparam int D     = 4;
  localparam int NBITS = 11;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic       baud_enable = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic       tx_even, tx_odd, tick_even, tick_odd;
  logic [3:0] bc_even, bc_odd;

  typedef struct {
    logic       tx_e;
    logic       tx_o;
    logic [3:0] bc;
    logic       tick;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: frame bits in transmit order, and enabled cycles since load.
  logic frame_e[NBITS];
  logic frame_o[NBITS];
  int   e = 0;

  uart_tx_datapath #(.CLK_FREQ(40), .BAUD(10), .PARITY_ODD(0)) dut_even (
    .clk(clk), .reset(reset), .load(load), .baud_enable(baud_enable),
    .data_in(data_in), .tx(tx_even), .bit_counter(bc_even), .baud_tick(tick_even)
  );

  uart_tx_datapath #(.CLK_FREQ(40), .BAUD(10), .PARITY_ODD(1)) dut_odd (
    .clk(clk), .reset(reset), .load(load), .baud_enable(baud_enable),
    .data_in(data_in), .tx(tx_odd), .bit_counter(bc_odd), .baud_tick(tick_odd)
  );

  always #5 clk = ~clk;

  function automatic void build_frame(input logic [7:0] d);
    int ones;
    ones = $countones(d);
    frame_e[0] = 1'b0;
    frame_o[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      frame_e[i+1] = d[i];
      frame_o[i+1] = d[i];
    end
    frame_e[9]  = (ones % 2) == 1;
    frame_o[9]  = (ones % 2) == 0;
    frame_e[10] = 1'b1;
    frame_o[10] = 1'b1;
  endfunction

  task automatic applyStimulus(input logic rst, input logic ld, input logic en,
                               input logic [7:0] d);
    exp_t x;
    int   idx;
    reset       = rst;
    load        = ld;
    baud_enable = en;
    data_in     = d;
    @(posedge clk);
    if (!rst) begin
      for (int k = 0; k < NBITS; k++) begin
        frame_e[k] = 1'b1;
        frame_o[k] = 1'b1;
      end
      e = 0;
    end else if (ld) begin
      build_frame(d);
      e = 0;
    end else if (en) begin
      e = e + 1;
    end else begin
      e = (e / D) * D;
    end
    idx = e / D;
    if (idx > NBITS) idx = NBITS;
    x.bc   = 4'(idx);
    x.tx_e = (idx < NBITS) ? frame_e[idx] : 1'b1;
    x.tx_o = (idx < NBITS) ? frame_o[idx] : 1'b1;
    x.tick = (e % D) == (D - 1);
    exp_q.push_back(x);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] actual,
                             input logic [3:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      checkOutput("tx_even",   {3'b000, tx_even},   {3'b000, x.tx_e});
      checkOutput("tx_odd",    {3'b000, tx_odd},    {3'b000, x.tx_o});
      checkOutput("bc_even",   bc_even,             x.bc);
      checkOutput("bc_odd",    bc_odd,              x.bc);
      checkOutput("tick_even", {3'b000, tick_even}, {3'b000, x.tick});
      checkOutput("tick_odd",  {3'b000, tick_odd},  {3'b000, x.tick});
    end
  end

  task automatic run(input int n, input logic en);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, en, 8'($urandom));
  endtask

  task automatic send(input logic [7:0] d);
    applyStimulus(1'b1, 1'b1, 1'($urandom_range(0, 1)), d);
  endtask

  initial begin
    $display("[TB] start");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h5A);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hC3);

    send(8'hA5);
    run(48, 1'b1);

    send(8'h01);
    run(46, 1'b1);

    send(8'($urandom));
    run(3 * D + 2, 1'b1);
    run(10, 1'b0);
    run(50, 1'b1);
    run(20, 1'b1);

    send(8'hFF);
    run(5 * D + 1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h3C);
    run(48, 1'b1);

    send(8'($urandom));
    run(17, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'($urandom));
    run(10, 1'b1);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 99) != 0),
                    1'($urandom_range(0, 39) == 0),
                    1'($urandom_range(0, 7) != 0),
                    8'($urandom));
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
